// File: rtl/dfc_result_collector.sv
// dfc_result_collector: folds 4-word DFC frames into {sum,min} records, FIFO'd.
// Ports: clk, reset(async low), din/din_valid in; out_valid/out_ready/out_sum/
// out_min record out; err_gap/err_drop sticky, clr_err clears them.
// Optional: define DFC_COLL_MAX_EN to add out_max (head record maximum word).
module dfc_result_collector #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  din,
  input  logic        din_valid,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [10:0] out_sum,
  output logic [8:0]  out_min,
`ifdef DFC_COLL_MAX_EN
  output logic [8:0]  out_max,
`endif
  output logic        err_gap,
  output logic        err_drop,
  input  logic        clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]    state;
  logic [1:0]    idx;
  logic [10:0]   acc_sum;
  logic [8:0]    acc_min;
  logic [10:0]   nxt_sum;
  logic [8:0]    nxt_min;

  logic [10:0]   mem_sum [FIFO_DEPTH];
  logic [8:0]    mem_min [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic last;
  logic gap;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign nxt_sum = acc_sum + {2'b00, din};
  assign nxt_min = (din < acc_min) ? din : acc_min;

  assign last = (state == COLLECT) && din_valid && (idx == 2'd3);
  assign gap  = (state == COLLECT) && !din_valid;
  assign pop  = out_valid && out_ready;
  assign full = (count == FULL_CNT);
  // A pop on the same edge frees the slot the new record needs.
  assign push = last && (!full || pop);
  assign drop = last && full && !pop;

`ifdef DFC_COLL_MAX_EN
  logic [8:0] acc_max;
  logic [8:0] nxt_max;
  logic [8:0] mem_max [FIFO_DEPTH];

  assign nxt_max = (din > acc_max) ? din : acc_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_max <= '0;
    end else if (din_valid && (state == IDLE || idx != 2'd3)) begin
      acc_max <= (state == IDLE) ? din : nxt_max;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_max[wr_ptr] <= nxt_max;
  end

  assign out_max = out_valid ? mem_max[rd_ptr] : '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      acc_sum <= '0;
      acc_min <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (din_valid) begin
            state   <= COLLECT;
            idx     <= 2'd1;
            acc_sum <= {2'b00, din};
            acc_min <= din;
          end
        end
        COLLECT: begin
          if (!din_valid || idx == 2'd3) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx     <= idx + 2'd1;
            acc_sum <= nxt_sum;
            acc_min <= nxt_min;
          end
        end
      endcase
    end
  end

  // Record storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum[wr_ptr] <= nxt_sum;
      mem_min[wr_ptr] <= nxt_min;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // New error events win over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_gap  <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      if (gap)          err_gap <= 1'b1;
      else if (clr_err) err_gap <= 1'b0;
      if (drop)          err_drop <= 1'b1;
      else if (clr_err)  err_drop <= 1'b0;
    end
  end

  assign out_valid = (count != '0);
  assign out_sum   = out_valid ? mem_sum[rd_ptr] : '0;
  assign out_min   = out_valid ? mem_min[rd_ptr] : '0;

endmodule

// File: tb/tb_dfc_result_collector.sv
// tb_dfc_result_collector: directed-vector bench for dfc_result_collector.
// Drives frames, gaps, overflow and resets; compares against hand values.
module tb_dfc_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  din;
  logic        din_valid;
  logic        out_ready;
  logic        out_valid;
  logic [10:0] out_sum;
  logic [8:0]  out_min;
`ifdef DFC_COLL_MAX_EN
  logic [8:0]  out_max;
`endif
  logic        err_gap;
  logic        err_drop;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  dfc_result_collector #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_min   (out_min),
`ifdef DFC_COLL_MAX_EN
    .out_max   (out_max),
`endif
    .err_gap   (err_gap),
    .err_drop  (err_drop),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [8:0] d);
    din       = d;
    din_valid = 1'b1;
    step();
  endtask

  task automatic frame(input logic [8:0] a, b, c, d);
    word(a);
    word(b);
    word(c);
    word(d);
    din_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_min", out_min, 0);
    check("rst_gap", err_gap, 0);
    check("rst_drop", err_drop, 0);
    step();
    step();
    reset = 1'b1;
    step();

    // basic frame, one-cycle latency, then popped
    out_ready = 1'b1;
    frame(1, 2, 3, 4);
    check("f1_valid", out_valid, 1);
    check("f1_sum", out_sum, 10);
    check("f1_min", out_min, 1);
`ifdef DFC_COLL_MAX_EN
    check("f1_max", out_max, 4);
`endif
    step();
    check("f1_pop_valid", out_valid, 0);
    check("f1_pop_sum", out_sum, 0);
    check("f1_gap", err_gap, 0);

    // max-value frame
    frame(511, 511, 511, 511);
    check("max_sum", out_sum, 2044);
    check("max_min", out_min, 511);
    step();
    check("max_pop", out_valid, 0);

    // gap discards partial frame
    out_ready = 1'b0;
    word(5);
    word(6);
    din_valid = 1'b0;
    step();
    check("gap_flag", err_gap, 1);
    check("gap_novalid", out_valid, 0);
    frame(7, 8, 9, 10);
    check("gap_valid", out_valid, 1);
    check("gap_sum", out_sum, 34);
    check("gap_min", out_min, 7);
    step();
    check("hold_valid", out_valid, 1);
    check("hold_sum", out_sum, 34);
    check("hold_min", out_min, 7);
    out_ready = 1'b1;
    step();
    check("gap_pop", out_valid, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("gap_clr", err_gap, 0);

    // overflow drops third frame
    out_ready = 1'b0;
    frame(1, 1, 1, 1);
    frame(2, 2, 2, 2);
    check("ovf_nodrop", err_drop, 0);
    frame(3, 3, 3, 3);
    check("ovf_drop", err_drop, 1);
    check("ovf_head_sum", out_sum, 4);
    check("ovf_head_min", out_min, 1);
    out_ready = 1'b1;
    step();
    check("ovf_2nd_valid", out_valid, 1);
    check("ovf_2nd_sum", out_sum, 8);
    check("ovf_2nd_min", out_min, 2);
    step();
    check("ovf_empty", out_valid, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", err_drop, 0);

    // full FIFO, completion coincides with pop
    out_ready = 1'b0;
    frame(10, 10, 10, 10);
    frame(20, 20, 20, 20);
    word(30);
    word(30);
    word(30);
    out_ready = 1'b1;
    word(30);
    out_ready = 1'b0;
    din_valid = 1'b0;
    check("cp_valid", out_valid, 1);
    check("cp_sum", out_sum, 80);
    check("cp_nodrop", err_drop, 0);
    step();
    check("cp_hold", out_sum, 80);
    out_ready = 1'b1;
    step();
    check("cp_new_sum", out_sum, 120);
    check("cp_new_min", out_min, 30);
    step();
    check("cp_empty", out_valid, 0);

    // error set beats coincident clear
    out_ready = 1'b0;
    frame(1, 1, 1, 1);
    frame(1, 1, 1, 1);
    word(2);
    word(2);
    word(2);
    clr_err = 1'b1;
    word(2);
    clr_err   = 1'b0;
    din_valid = 1'b0;
    check("prio_drop", err_drop, 1);
    check("prio_sum", out_sum, 4);
    clr_err   = 1'b1;
    out_ready = 1'b1;
    step();
    clr_err = 1'b0;
    check("prio_clr", err_drop, 0);
    step();
    check("prio_empty", out_valid, 0);

    // async reset mid-frame
    out_ready = 1'b0;
    frame(5, 5, 5, 5);
    word(1);
    word(2);
    reset = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_sum", out_sum, 0);
    check("mrst_min", out_min, 0);
    check("mrst_gap", err_gap, 0);
    din_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("mrst_nogap", err_gap, 0);
    check("mrst_empty", out_valid, 0);
    frame(4, 3, 2, 1);
    check("mrst_f_valid", out_valid, 1);
    check("mrst_f_sum", out_sum, 10);
    check("mrst_f_min", out_min, 1);
    check("mrst_f_gap", err_gap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dfc_result_collector.md
DFC_RESULT_COLLECTOR -- requirements
Module: dfc_result_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of completed-frame records buffered (legal values 2 or 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port din  input  9  result word from the upstream DFC dataout.
REQ-005 SHALL have port din_valid  input  1  din qualifier, driven by upstream output_valid.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the head record this cycle.
REQ-007 SHALL have port out_valid  output  1  FIFO non-empty; head record presented.
REQ-008 SHALL have port out_sum  output  11  head record sum of 4 words.
REQ-009 SHALL have port out_min  output  9  head record minimum word.
REQ-010 SHALL have port err_gap  output  1  sticky flag: partial frame discarded.
REQ-011 SHALL have port err_drop  output  1  sticky flag: completed frame lost because the FIFO was full.
REQ-012 SHALL have port clr_err  input  1  synchronous clear of both sticky flags.

Function
REQ-013 SHALL group din words into frames of exactly 4 consecutive din_valid cycles, tracked by a 2-bit index idx (0..3).
REQ-014 SHALL use a collector FSM with states IDLE (idx=0, no partial frame) and COLLECT (idx 1..3); IDLE->COLLECT on din_valid; COLLECT->IDLE on 4th word or on gap.
REQ-015 SHALL accumulate sum unsigned at 11 bits (maximum 4*511=2044, no overflow) and min by unsigned compare, first word loading both.
REQ-016 SHALL, on the edge capturing the 4th word, push {acc+din, min(accmin,din)} into the FIFO, so that out_valid rises the next cycle (latency 1 cycle after the last word).
REQ-017 SHALL treat din_valid low while in COLLECT as a gap: discard the partial frame, go to IDLE, and set err_gap.
REQ-018 SHALL, when a frame completes while the FIFO is full and out_ready is low, drop the frame, set err_drop, and leave FIFO contents unchanged.
REQ-019 SHALL, when full and a pop (out_valid & out_ready) coincides with completion, perform both the pop and the push and keep the count at FIFO_DEPTH.
REQ-020 SHALL pop on out_valid & out_ready; out_sum/out_min hold stable while out_valid is high and out_ready is low.
REQ-021 SHALL drive out_sum and out_min to 0 when the FIFO is empty.
REQ-022 SHALL implement the FIFO as a circular buffer with wrap-around read/write pointers and an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-023 SHALL give set priority over clear when clr_err coincides with a new error event.
REQ-024 SHALL be independent of upstream FIFO/LIFO ordering; words accumulate in arrival order.

Reset
REQ-025 SHALL, on reset low, asynchronously clear FSM to IDLE, idx, accumulators, pointers, count, err_gap and err_drop to 0, giving out_valid=0, out_sum=0, out_min=0.
REQ-026 SHALL abandon a partial frame on reset mid-frame without flagging err_gap.

Configuration
REQ-027 SHALL, with macro DFC_COLL_MAX_EN defined, add output port out_max (output, 9 bits, head record maximum word) tracked and stored alongside min, reading 0 when empty.
REQ-028 SHALL, without DFC_COLL_MAX_EN, have no out_max port and no max storage or compare logic.

Verification
REQ-029 SHALL cover: words 1,2,3,4 on 4 consecutive valid cycles, out_ready=1 -> out_valid for one cycle after the 4th word, out_sum=10, out_min=1 (out_max=4 if enabled).
REQ-030 SHALL cover: 511 x4 -> out_sum=2044, out_min=511.
REQ-031 SHALL cover: 5,6, gap cycle, then 7,8,9,10 -> err_gap=1 and a single record with sum=34, min=7.
REQ-032 SHALL cover: out_ready=0, three frames at FIFO_DEPTH=2 -> first two retained in order, err_drop=1; then out_ready=1 -> two pops, then out_valid=0.
REQ-033 SHALL cover: FIFO full, 4th word coincides with a pop -> count stays 2, new record appears after the older one.
REQ-034 SHALL cover: reset low after 2 words -> all outputs 0, err_gap=0; next 4 words form a clean frame.
